// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read per instruction and
// hands the fetched word to the core over a valid/ready handshake.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic [31:0] npc,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic [31:0]        inst_q;
  logic               fault_q;
  logic [31:0]        cnt_q;

  logic               misaligned_c;
  logic               timeout_hit_c;
  logic [CNT_W-1:0]   wait_cnt_d;

  assign misaligned_c  = (pc_q[1:0] != 2'b00);
  assign timeout_hit_c = TO_EN && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign wait_cnt_d    = wait_cnt_q + CNT_W'(1);

  // Misaligned PCs never reach memory; they become a fault in HOLD instead.
  assign imem_req_valid = (state_q == ST_REQ) && !rst && !misaligned_c;
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == ST_HOLD);
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign out_fault      = fault_q;
  assign fetch_cnt      = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      wait_cnt_q <= '0;
      inst_q     <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (misaligned_c) begin
            inst_q  <= '0;
            fault_q <= 1'b1;
            state_q <= ST_HOLD;
          end else if (imem_req_ready) begin
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response arriving on the timeout cycle takes priority.
          if (imem_resp_valid) begin
            inst_q  <= imem_resp_data;
            fault_q <= imem_resp_err;
            state_q <= ST_HOLD;
          end else if (timeout_hit_c) begin
            inst_q  <= '0;
            fault_q <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            pc_q    <= npc;
            cnt_q   <= cnt_q + 32'd1;
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

endmodule
